layer_stream_bridge: RTL and testbench
======================================

// Module: layer_stream_bridge
// PURPOSE
//  Downstream of an nn_layer: captures the parallel layer_out word once every neuron has fired,
//  applies optional ReLU, then serialises it one value per cycle as data_in/input_valid/local_addr
//  for the next nn_layer (whose Weight_Memory read is synchronous, so the address leads the data).
//  Flags capture overruns and incoherent neuron valids.
// PARAMETERS
//  NUM_NEURONS  128  neurons in upstream layer = NUM_INPUTS of downstream layer
//  DATA_WIDTH   16   signed two's-complement word width
//  RELU         1    1: negative values clamp to 0 at capture; 0: pass-through
//  ADDR_LEAD    1    cycles local_addr leads out_data/out_valid (legal: 0 or 1)
// PORTS
//  clk          in   1                        clock, all logic on posedge
//  rst          in   1                        async active-high reset
//  in_valids    in   NUM_NEURONS              upstream out_valids
//  layer_in     in   NUM_NEURONS*DATA_WIDTH   upstream layer_out; neuron i at [i*DATA_WIDTH +: DATA_WIDTH]
//  out_data     out  DATA_WIDTH               to next layer data_in
//  out_valid    out  1                        to next layer input_valid
//  local_addr   out  32                       to next layer local_addr (weight index)
//  busy         out  1                        high from capture until last word issued
//  done         out  1                        1-cycle pulse after last out_valid
//  err_overrun  out  1                        sticky: full capture request while busy
//  err_partial  out  1                        sticky: in_valids nonzero but not all-ones
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, idx=0; out_data=0, out_valid=0, local_addr=0,
//   busy=0, done=0, err_overrun=0, err_partial=0. Buffer contents don't-care. Mid-stream reset
//   aborts the stream; no further out_valid until a new capture.
//  FSM IDLE -> STREAM -> (LAST, ADDR_LEAD=1 only) -> DONE -> IDLE.
//  IDLE: if &in_valids at edge k: load all NUM_NEURONS words into buffer (ReLU applied per word
//   if RELU=1: MSB set -> 0), idx=0, busy=1 from k+1, go STREAM. Otherwise stay.
//  Capture and in_valids test use same-edge layer_in; no extra stall.
//  STREAM: each cycle local_addr=idx, idx++. ADDR_LEAD=1: out_data=buf[idx], out_valid=1
//   one cycle after matching local_addr. ADDR_LEAD=0: same cycle. Exactly NUM_NEURONS
//   out_valid cycles per capture, contiguous, addresses 0..NUM_NEURONS-1 ascending.
//  Latency (ADDR_LEAD=1): capture edge k -> local_addr=0 during k+1 -> first out_valid k+2 ->
//   last out_valid k+NUM_NEURONS+1 -> done=1 and busy=0 in k+NUM_NEURONS+2 -> IDLE.
//  local_addr holds last issued value when not streaming; out_data returns to 0 when !out_valid.
//  idx width $clog2(NUM_NEURONS)+1; terminal test idx==NUM_NEURONS-1, no wrap past it.
//  &in_valids while busy/DONE: ignored (buffer unchanged, stream unaffected), err_overrun<=1.
//  |in_valids && !&in_valids in any state: err_partial<=1; no capture.
//  Capture in the DONE->IDLE cycle is not accepted (counts as overrun); accepted next cycle.
//  No backpressure: downstream must accept one word per cycle while out_valid.
// TESTING
//  1. NUM_NEURONS=4, RELU=0, layer_in={16'h0004,16'hFFFE,16'h7FFF,16'h0001}, in_valids=4'hF one
//     cycle -> out_data 0001,7FFF,FFFE,0004 on 4 contiguous out_valid cycles, local_addr 0..3
//     one cycle ahead, done pulses once, busy 5 cycles wide.
//  2. Same stimulus RELU=1 -> out_data 0001,7FFF,0000,0004; 8000 input -> 0000.
//  3. in_valids=4'hF again at 2nd cycle of stream -> stream continues with original values,
//     err_overrun=1 and stays 1 until rst.
//  4. in_valids=4'b0101 in IDLE -> no out_valid, busy=0, err_partial=1.
//  5. Assert rst at 3rd out_valid -> all outputs 0 asynchronously; next capture streams from addr 0
//     with new data only.
//  6. Two captures back-to-back (second one cycle after done) -> 2*NUM_NEURONS valids, no error;
//     ADDR_LEAD=0 run shows local_addr aligned with out_valid.

Source files
------------

// File: rtl/layer_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module   : layer_stream_bridge
// Purpose  : Captures a full parallel layer output once every neuron has
//            fired, optionally clamps negatives (ReLU), then serialises the
//            words one per cycle with a weight address for the next layer.
// Revision : 1.0  initial release
// ============================================================================
module layer_stream_bridge #(
  parameter int NUM_NEURONS = 128,
  parameter int DATA_WIDTH  = 16,
  parameter int RELU        = 1,
  parameter int ADDR_LEAD   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS-1:0]            in_valids,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_in,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  output logic [31:0]                       local_addr,
  output logic                              busy,
  output logic                              done,
  output logic                              err_overrun,
  output logic                              err_partial
);

  localparam int IDX_W = $clog2(NUM_NEURONS) + 1;
  localparam int SEL_W = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_LAST   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_next;
  logic [SEL_W-1:0]      sel;
  logic [SEL_W-1:0]      sel_next;
  logic                  all_valid;
  logic                  any_valid;
  logic                  capture;
  logic                  at_last;
  logic [DATA_WIDTH-1:0] cap_word [NUM_NEURONS];
  logic [DATA_WIDTH-1:0] buffer   [NUM_NEURONS];

  assign all_valid = &in_valids;
  assign any_valid = |in_valids;
  assign capture   = (state == S_IDLE) && all_valid;
  assign at_last   = (idx == LAST_IDX);
  assign idx_next  = idx + IDX_W'(1);
  assign sel       = idx[SEL_W-1:0];
  assign sel_next  = idx_next[SEL_W-1:0];

  // Per-neuron word as it will be stored: sign bit set clamps to zero under ReLU.
  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_word
    assign cap_word[i] = ((RELU != 0) && layer_in[i*DATA_WIDTH + DATA_WIDTH - 1])
                         ? '0 : layer_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state: the LAST state only exists to let the lagging data word drain.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (capture) state_next = S_STREAM;
      S_STREAM: if (at_last) state_next = (ADDR_LEAD != 0) ? S_LAST : S_DONE;
      S_LAST:   state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Capture buffer; contents are don't-care after reset so it carries none.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NUM_NEURONS; i++) buffer[i] <= cap_word[i];
    end
  end

  // Stream datapath: address counter, data/valid issue, busy/done handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      local_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (capture) begin
            idx        <= '0;
            local_addr <= '0;
            busy       <= 1'b1;
            // Without address lead the first word goes out alongside address 0.
            if (ADDR_LEAD == 0) begin
              out_valid <= 1'b1;
              out_data  <= cap_word[0];
            end
          end
        end
        S_STREAM: begin
          if (ADDR_LEAD != 0) begin
            // Data for the address presented this cycle appears next cycle.
            out_valid <= 1'b1;
            out_data  <= buffer[sel];
            if (!at_last) begin
              idx        <= idx_next;
              local_addr <= 32'(idx_next);
            end
          end else begin
            if (at_last) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              idx        <= idx_next;
              local_addr <= 32'(idx_next);
              out_valid  <= 1'b1;
              out_data   <= buffer[sel_next];
            end
          end
        end
        S_LAST: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        S_DONE: begin
          // One idle turnaround cycle; captures here are rejected.
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overrun <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      if (all_valid && (state != S_IDLE)) err_overrun <= 1'b1;
      if (any_valid && !all_valid)        err_partial <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_layer_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_stream_bridge
// Purpose  : Self-checking bench for layer_stream_bridge; three instances
//            (RELU=0/lead 1, RELU=1/lead 1, RELU=1/lead 0) share stimulus
//            and are compared against a cycle-offset reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_layer_stream_bridge;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int ND = 3;

  logic              clk;
  logic              rst;
  logic [N-1:0]      in_valids;
  logic [N*DW-1:0]   layer_in;

  logic [DW-1:0] od [ND];
  logic          ov [ND];
  logic [31:0]   la [ND];
  logic          bz [ND];
  logic          dn [ND];
  logic          eo [ND];
  logic          ep [ND];

  int n_cmp;
  int n_fail;
  logic exp_overrun;
  logic exp_partial;

  layer_stream_bridge #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .RELU(0), .ADDR_LEAD(1)) dut0 (
    .clk(clk), .rst(rst), .in_valids(in_valids), .layer_in(layer_in),
    .out_data(od[0]), .out_valid(ov[0]), .local_addr(la[0]), .busy(bz[0]),
    .done(dn[0]), .err_overrun(eo[0]), .err_partial(ep[0]));

  layer_stream_bridge #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .RELU(1), .ADDR_LEAD(1)) dut1 (
    .clk(clk), .rst(rst), .in_valids(in_valids), .layer_in(layer_in),
    .out_data(od[1]), .out_valid(ov[1]), .local_addr(la[1]), .busy(bz[1]),
    .done(dn[1]), .err_overrun(eo[1]), .err_partial(ep[1]));

  layer_stream_bridge #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .RELU(1), .ADDR_LEAD(0)) dut2 (
    .clk(clk), .rst(rst), .in_valids(in_valids), .layer_in(layer_in),
    .out_data(od[2]), .out_valid(ov[2]), .local_addr(la[2]), .busy(bz[2]),
    .done(dn[2]), .err_overrun(eo[2]), .err_partial(ep[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Configuration of each instance.
  function automatic int lead_of(input int d);
    return (d == 2) ? 0 : 1;
  endfunction

  function automatic int relu_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  // Reference rule: with ReLU, any negative word becomes zero.
  function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w, input int relu);
    if (relu != 0 && $signed(w) < 0) return '0;
    return w;
  endfunction

  function automatic logic [N*DW-1:0] rand_words();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // Captures `words` now, then checks every instance cycle by cycle.
  // Cycle t counts from 1 = first cycle after the capture edge.
  // inject_t: cycle after which a second full capture is attempted (0 = none).
  // abort_t : cycle at which reset is asserted mid-stream (0 = none).
  task automatic test_stream(input logic [N*DW-1:0] words, input int inject_t,
                             input int abort_t, input string tag);
    logic clr;
    layer_in  = words;
    in_valids = '1;
    clr       = 1'b1;
    @(negedge clk);
    for (int t = 1; t <= N + 2; t++) begin
      if (clr) begin
        in_valids = '0;
        layer_in  = rand_words();
        clr       = 1'b0;
      end
      for (int d = 0; d < ND; d++) begin
        int first;
        int last;
        int ea;
        logic e_v;
        logic [DW-1:0] e_d;
        first = 1 + lead_of(d);
        last  = N + lead_of(d);
        e_v   = (t >= first) && (t <= last);
        e_d   = e_v ? model_word(words[(t-first)*DW +: DW], relu_of(d)) : '0;
        ea    = (t - 1 < N - 1) ? t - 1 : N - 1;
        n_cmp++;
        if (ov[d] !== e_v) begin
          n_fail++;
          $display("FAIL %s out_valid dut%0d t=%0d: got %b want %b", tag, d, t, ov[d], e_v);
        end
        n_cmp++;
        if (od[d] !== e_d) begin
          n_fail++;
          $display("FAIL %s out_data dut%0d t=%0d: got %h want %h", tag, d, t, od[d], e_d);
        end
        n_cmp++;
        if (la[d] !== 32'(ea)) begin
          n_fail++;
          $display("FAIL %s local_addr dut%0d t=%0d: got %0d want %0d", tag, d, t, la[d], ea);
        end
        n_cmp++;
        if (bz[d] !== (t <= last)) begin
          n_fail++;
          $display("FAIL %s busy dut%0d t=%0d: got %b want %b", tag, d, t, bz[d], (t <= last));
        end
        n_cmp++;
        if (dn[d] !== (t == last + 1)) begin
          n_fail++;
          $display("FAIL %s done dut%0d t=%0d: got %b want %b", tag, d, t, dn[d], (t == last + 1));
        end
        n_cmp++;
        if (eo[d] !== exp_overrun || ep[d] !== exp_partial) begin
          n_fail++;
          $display("FAIL %s err flags dut%0d t=%0d: got ov=%b pa=%b want ov=%b pa=%b",
                   tag, d, t, eo[d], ep[d], exp_overrun, exp_partial);
        end
      end
      if (t == inject_t) begin
        layer_in    = rand_words();
        in_valids   = '1;
        clr         = 1'b1;
        exp_overrun = 1'b1;
      end
      if (t == abort_t) begin
        #2 rst = 1'b1;
        #1;
        exp_overrun = 1'b0;
        exp_partial = 1'b0;
        for (int d = 0; d < ND; d++) begin
          n_cmp++;
          if ({od[d], ov[d], la[d], bz[d], dn[d], eo[d], ep[d]} !== '0) begin
            n_fail++;
            $display("FAIL %s async reset dut%0d: got data=%h v=%b addr=%0d busy=%b done=%b eo=%b ep=%b want all 0",
                     tag, d, od[d], ov[d], la[d], bz[d], dn[d], eo[d], ep[d]);
          end
        end
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    in_valids   = '0;
    layer_in    = '0;
    exp_overrun = 1'b0;
    exp_partial = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      n_cmp++;
      if ({od[d], ov[d], la[d], bz[d], dn[d], eo[d], ep[d]} !== '0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got data=%h v=%b addr=%0d busy=%b done=%b eo=%b ep=%b want all 0",
                 d, od[d], ov[d], la[d], bz[d], dn[d], eo[d], ep[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [N*DW-1:0] w;
    w = {16'h0004, 16'hFFFE, 16'h7FFF, 16'h0001};
    test_stream(w, 0, 0, "basic");
    w = {16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF};
    test_stream(w, 0, 0, "relu_edges");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) test_stream(rand_words(), 0, 0, "random");
  endtask

  task automatic test_back_to_back();
    test_stream(rand_words(), 0, 0, "b2b_first");
    test_stream(rand_words(), 0, 0, "b2b_second");
  endtask

  task automatic test_overrun();
    test_stream(rand_words(), 2, 0, "overrun");
    repeat (3) @(negedge clk);
    test_stream(rand_words(), 0, 0, "after_overrun");
  endtask

  task automatic test_partial();
    in_valids = 4'b0101;
    layer_in  = rand_words();
    @(negedge clk);
    in_valids   = '0;
    exp_partial = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (ov[d] !== 1'b0 || bz[d] !== 1'b0 || ep[d] !== 1'b1) begin
          n_fail++;
          $display("FAIL partial dut%0d c=%0d: got v=%b busy=%b ep=%b want v=0 busy=0 ep=1",
                   d, c, ov[d], bz[d], ep[d]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    test_stream(rand_words(), 0, 4, "mid_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (ov[d] !== 1'b0 || bz[d] !== 1'b0 || la[d] !== 32'd0) begin
          n_fail++;
          $display("FAIL post_reset_idle dut%0d c=%0d: got v=%b busy=%b addr=%0d want 0 0 0",
                   d, c, ov[d], bz[d], la[d]);
        end
      end
    end
    test_stream(rand_words(), 0, 0, "after_reset");
    test_stream(rand_words(), 0, 0, "after_reset_b2b");
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_overrun();
    test_partial();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
